// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu
// Execute stage with an iterative multiply/divide unit and a registered EX/MEM
// output. Single-cycle ALU ops load EX/MEM at the next edge. mul (and divu
// when EXEC_MDU_DIV_EN is defined) run one bit per cycle. While they run,
// stall_out holds the front end and EX/MEM receives bubbles.
// Build option: define EXEC_MDU_DIV_EN to include the restoring divider.
// Without it, funct 011010 decodes as an unknown op.
module execute_stage_mdu #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [1:0]      wb_ctl,
    input  logic [2:0]      m_ctl,
    input  logic            regdst,
    input  logic            alusrc,
    input  logic [1:0]      aluop,
    input  logic [XLEN-1:0] npcout,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic [XLEN-1:0] s_extendout,
    input  logic [REGW-1:0] instrout_2016,
    input  logic [REGW-1:0] instrout_1511,
    input  logic [5:0]      funct,
    output logic            stall_out,
    output logic            ex_valid,
    output logic [1:0]      wb_ctlout,
    output logic            branch,
    output logic            memread,
    output logic            memwrite,
    output logic [XLEN-1:0] EX_MEM_NPC,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] rdata2out,
    output logic            zero,
    output logic [REGW-1:0] five_bit_muxout
);

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_DIV, OP_ZERO
    } alu_op_t;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    alu_op_t         alu_op;
    logic            is_mdu_op;
    logic [XLEN-1:0] operand_b;
    logic [REGW-1:0] dest_reg;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] sc_result;

    state_t          state_q, state_d;
    logic            accept;
    logic            last_iter;

    // MDU working registers: acc = product / remainder,
    // opa = multiplicand / dividend-then-quotient, opb = multiplier / divisor
    logic [CNTW-1:0] cnt_q;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] mdu_result;
    logic [1:0]      cap_wb_q;
    logic [2:0]      cap_m_q;
    logic [REGW-1:0] cap_dst_q;
    logic [XLEN-1:0] cap_npc_q;
    logic [XLEN-1:0] cap_rd2_q;
`ifdef EXEC_MDU_DIV_EN
    logic            is_div_q;
    logic [XLEN:0]   rem_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
`endif

    // EX/MEM next-state
    logic            exm_valid_d, exm_valid_q;
    logic [1:0]      exm_wb_d, exm_wb_q;
    logic [2:0]      exm_m_d, exm_m_q;
    logic [XLEN-1:0] exm_npc_d, exm_npc_q;
    logic [XLEN-1:0] exm_res_d, exm_res_q;
    logic [XLEN-1:0] exm_rd2_d, exm_rd2_q;
    logic            exm_zero_d, exm_zero_q;
    logic [REGW-1:0] exm_dst_d, exm_dst_q;

    assign operand_b = alusrc ? s_extendout : rdata2;
    assign dest_reg  = regdst ? instrout_1511 : instrout_2016;
    assign br_target = npcout + s_extendout;
    assign is_mdu_op = (alu_op == OP_MUL) || (alu_op == OP_DIV);
    assign last_iter = (cnt_q == CNTW'(XLEN - 1));

    // ALU control decode from aluop/funct
    always_comb begin
        alu_op = OP_ADD;
        case (aluop)
            2'b00:   alu_op = OP_ADD;
            2'b01:   alu_op = OP_SUB;
            2'b11:   alu_op = OP_ADD;
            default: begin
                case (funct)
                    6'b100000: alu_op = OP_ADD;
                    6'b100010: alu_op = OP_SUB;
                    6'b100100: alu_op = OP_AND;
                    6'b100101: alu_op = OP_OR;
                    6'b101010: alu_op = OP_SLT;
                    6'b011000: alu_op = OP_MUL;
`ifdef EXEC_MDU_DIV_EN
                    6'b011010: alu_op = OP_DIV;
`endif
                    default:   alu_op = OP_ZERO;
                endcase
            end
        endcase
    end

    // Single-cycle ALU result; MDU ops never use this path
    always_comb begin
        sc_result = '0;
        case (alu_op)
            OP_ADD:  sc_result = rdata1 + operand_b;
            OP_SUB:  sc_result = rdata1 - operand_b;
            OP_AND:  sc_result = rdata1 & operand_b;
            OP_OR:   sc_result = rdata1 | operand_b;
            OP_SLT:  sc_result = {{(XLEN-1){1'b0}}, ($signed(rdata1) < $signed(operand_b))};
            default: sc_result = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state; flush returns to IDLE from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_BUSY;
            S_BUSY:  if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // FSM outputs: accept a new MDU op, and hold the front end
    always_comb begin
        accept    = (state_q == S_IDLE) && in_valid && is_mdu_op && !flush;
        stall_out = accept || (state_q == S_BUSY);
    end

    // One MDU iteration: shift-add multiply, or restoring divide step
    always_comb begin
        acc_d = acc_q + (opb_q[0] ? opa_q : '0);
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
`ifdef EXEC_MDU_DIV_EN
        rem_shift = {acc_q, opa_q[XLEN-1]};
        div_ge    = (rem_shift >= {1'b0, opb_q});
        div_diff  = rem_shift[XLEN-1:0] - opb_q;
        if (is_div_q) begin
            acc_d = div_ge ? div_diff : rem_shift[XLEN-1:0];
            opa_d = {opa_q[XLEN-2:0], div_ge};
            opb_d = opb_q;
        end
`endif
    end

`ifdef EXEC_MDU_DIV_EN
    assign mdu_result = is_div_q ? opa_q : acc_q;
`else
    assign mdu_result = acc_q;
`endif

    // MDU operand capture on accept, then one iteration per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            cap_wb_q  <= '0;
            cap_m_q   <= '0;
            cap_dst_q <= '0;
            cap_npc_q <= '0;
            cap_rd2_q <= '0;
`ifdef EXEC_MDU_DIV_EN
            is_div_q  <= 1'b0;
`endif
        end else if (accept) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= rdata1;
            opb_q     <= operand_b;
            cap_wb_q  <= wb_ctl;
            cap_m_q   <= m_ctl;
            cap_dst_q <= dest_reg;
            cap_npc_q <= br_target;
            cap_rd2_q <= rdata2;
`ifdef EXEC_MDU_DIV_EN
            is_div_q  <= (alu_op == OP_DIV);
`endif
        end else if (state_q == S_BUSY) begin
            cnt_q <= cnt_q + CNTW'(1);
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
        end
    end

    // EX/MEM load select: flush > MDU completion > stall bubble > new op > bubble
    always_comb begin
        exm_valid_d = 1'b0;
        exm_wb_d    = '0;
        exm_m_d     = '0;
        exm_npc_d   = '0;
        exm_res_d   = '0;
        exm_rd2_d   = '0;
        exm_zero_d  = 1'b0;
        exm_dst_d   = '0;
        if (flush) begin
            exm_valid_d = 1'b0;
        end else if (state_q == S_DONE) begin
            exm_valid_d = 1'b1;
            exm_wb_d    = cap_wb_q;
            exm_m_d     = cap_m_q;
            exm_npc_d   = cap_npc_q;
            exm_res_d   = mdu_result;
            exm_rd2_d   = cap_rd2_q;
            exm_zero_d  = (mdu_result == '0);
            exm_dst_d   = cap_dst_q;
        end else if (stall_out) begin
            exm_valid_d = 1'b0;
        end else if (in_valid) begin
            exm_valid_d = 1'b1;
            exm_wb_d    = wb_ctl;
            exm_m_d     = m_ctl;
            exm_npc_d   = br_target;
            exm_res_d   = sc_result;
            exm_rd2_d   = rdata2;
            exm_zero_d  = (sc_result == '0);
            exm_dst_d   = dest_reg;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exm_valid_q <= 1'b0;
            exm_wb_q    <= '0;
            exm_m_q     <= '0;
            exm_npc_q   <= '0;
            exm_res_q   <= '0;
            exm_rd2_q   <= '0;
            exm_zero_q  <= 1'b0;
            exm_dst_q   <= '0;
        end else begin
            exm_valid_q <= exm_valid_d;
            exm_wb_q    <= exm_wb_d;
            exm_m_q     <= exm_m_d;
            exm_npc_q   <= exm_npc_d;
            exm_res_q   <= exm_res_d;
            exm_rd2_q   <= exm_rd2_d;
            exm_zero_q  <= exm_zero_d;
            exm_dst_q   <= exm_dst_d;
        end
    end

    assign ex_valid        = exm_valid_q;
    assign wb_ctlout       = exm_wb_q;
    assign branch          = exm_m_q[2];
    assign memread         = exm_m_q[1];
    assign memwrite        = exm_m_q[0];
    assign EX_MEM_NPC      = exm_npc_q;
    assign alu_result      = exm_res_q;
    assign rdata2out       = exm_rd2_q;
    assign zero            = exm_zero_q;
    assign five_bit_muxout = exm_dst_q;

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Self-checking bench for execute_stage_mdu. Inputs change and outputs are
// sampled on the falling edge. Expected values come from a plain-arithmetic
// reference of the ALU rules.
module tb_execute_stage_mdu;
    localparam int XLEN  = 32;
    localparam int REGW  = 5;
    localparam int CNTW  = 6;
    localparam int REC_W = 7 + REGW + 3 * XLEN;
`ifdef EXEC_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, flush;
    logic [1:0]      wb_ctl;
    logic [2:0]      m_ctl;
    logic            regdst, alusrc;
    logic [1:0]      aluop;
    logic [XLEN-1:0] npcout, rdata1, rdata2, s_extendout;
    logic [REGW-1:0] instrout_2016, instrout_1511;
    logic [5:0]      funct;
    logic            stall_out, ex_valid;
    logic [1:0]      wb_ctlout;
    logic            branch, memread, memwrite;
    logic [XLEN-1:0] EX_MEM_NPC, alu_result, rdata2out;
    logic            zero;
    logic [REGW-1:0] five_bit_muxout;

    int n_checks = 0;
    int n_errors = 0;

    execute_stage_mdu #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
        .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc),
        .aluop(aluop), .npcout(npcout), .rdata1(rdata1), .rdata2(rdata2),
        .s_extendout(s_extendout), .instrout_2016(instrout_2016),
        .instrout_1511(instrout_1511), .funct(funct), .stall_out(stall_out),
        .ex_valid(ex_valid), .wb_ctlout(wb_ctlout), .branch(branch),
        .memread(memread), .memwrite(memwrite), .EX_MEM_NPC(EX_MEM_NPC),
        .alu_result(alu_result), .rdata2out(rdata2out), .zero(zero),
        .five_bit_muxout(five_bit_muxout)
    );

    always #5 clk = ~clk;

    // Reference ALU semantics
    function automatic logic [XLEN-1:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (op != 2'b10) return (op == 2'b01) ? a - b : a + b;
        case (f)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h2a: return ($signed(a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
            6'h18: return a * b;
            6'h1a: begin
                if (!DIV_EN) return '0;
                if (b == 0) return '1;
                return a / b;
            end
            default: return '0;
        endcase
    endfunction

    // Expected EX/MEM record for the instruction currently on the inputs
    function automatic logic [REC_W-1:0] make_rec(input logic [XLEN-1:0] res);
        return {1'b1, wb_ctl, m_ctl, (regdst ? instrout_1511 : instrout_2016), (res == 0),
                npcout + s_extendout, rdata2, res};
    endfunction

    function automatic logic [REC_W-1:0] dut_rec();
        return {ex_valid, wb_ctlout, branch, memread, memwrite, five_bit_muxout, zero,
                EX_MEM_NPC, rdata2out, alu_result};
    endfunction

    task automatic randomize_ctl();
        wb_ctl        = 2'($urandom);
        m_ctl         = 3'($urandom);
        regdst        = 1'($urandom);
        alusrc        = 1'($urandom);
        instrout_2016 = REGW'($urandom);
        instrout_1511 = REGW'($urandom);
        npcout        = XLEN'($urandom);
        s_extendout   = XLEN'($urandom);
        rdata2        = XLEN'($urandom);
        flush         = 1'b0;
        in_valid      = 1'b1;
    endtask

    // One single-cycle op: no stall, result one cycle later
    task automatic do_single(input logic [1:0] op, input logic [5:0] f,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input string tag);
        logic [REC_W-1:0] want;
        randomize_ctl();
        aluop = op; funct = f; rdata1 = a;
        if (alusrc) s_extendout = b; else rdata2 = b;
        want = make_rec(ref_alu(op, f, a, b));
        #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_errors++; $display("FAIL %s_stall: got %b want 0", tag, stall_out);
        end
        @(negedge clk);
        n_checks++;
        if (dut_rec() !== want) begin
            n_errors++; $display("FAIL %s: got %h want %h", tag, dut_rec(), want);
        end
        else $display("ok %s aluop=%b funct=%h a=%h b=%h res=%h", tag, op, f, a, b, alu_result);
    endtask

    // One MDU op from cycle 0 to the result in cycle XLEN+2; inputs left on the op
    task automatic run_mdu(input logic [5:0] f, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input string tag);
        logic [REC_W-1:0] want;
        logic [5:0] bub;
        randomize_ctl();
        aluop = 2'b10; funct = f; rdata1 = a;
        if (alusrc) s_extendout = b; else rdata2 = b;
        want = make_rec(ref_alu(2'b10, f, a, b));
        #1;
        n_checks++;
        if (stall_out !== 1'b1) begin
            n_errors++; $display("FAIL %s_stall_c0: got %b want 1", tag, stall_out);
        end
        for (int c = 1; c <= XLEN + 2; c++) begin
            @(negedge clk);
            if (c <= XLEN + 1) begin
                bub = {ex_valid, wb_ctlout, branch, memread, memwrite};
                n_checks++;
                if (bub !== 6'b0) begin
                    n_errors++; $display("FAIL %s_bubble_c%0d: got %b want 000000", tag, c, bub);
                end
                n_checks++;
                if (stall_out !== (c <= XLEN)) begin
                    n_errors++; $display("FAIL %s_stall_c%0d: got %b want %b", tag, c, stall_out, c <= XLEN);
                end
            end else begin
                n_checks++;
                if (dut_rec() !== want) begin
                    n_errors++; $display("FAIL %s_result: got %h want %h", tag, dut_rec(), want);
                end
                else $display("ok %s funct=%h a=%h b=%h res=%h", tag, f, a, b, alu_result);
            end
        end
    endtask

    task automatic idle_check(input int cycles, input string tag);
        in_valid = 1'b0; flush = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_rec() !== '0 || stall_out !== 1'b0) begin
                n_errors++; $display("FAIL %s_c%0d: got rec %h stall %b want 0", tag, c, dut_rec(), stall_out);
            end
        end
    endtask

    task automatic test_reset();
        randomize_ctl();
        in_valid = 1'b0; rst_n = 1'b0; aluop = 2'b00; funct = '0; rdata1 = '0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (dut_rec() !== '0 || stall_out !== 1'b0) begin
            n_errors++; $display("FAIL reset: got rec %h stall %b want 0", dut_rec(), stall_out);
        end
        else $display("ok reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        randomize_ctl();
        aluop = 2'b10; funct = 6'h18; rdata1 = 32'h1234_5678; rdata2 = 32'h10; alusrc = 1'b0;
        for (int c = 1; c <= 6; c++) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_rec() !== '0 || stall_out !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid_mul: got rec %h stall %b want 0", dut_rec(), stall_out);
        end
        else $display("ok reset_mid_mul");
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(XLEN + 4, "post_reset_idle");
    endtask

    task automatic test_single_cycle();
        logic [1:0] op;
        logic [5:0] f;
        logic [5:0] fl [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        do_single(2'b10, 6'h20, 32'h7FFF_FFFF, 32'h1, "add_ovf");
        n_checks++;
        if (alu_result !== 32'h8000_0000 || zero !== 1'b0) begin
            n_errors++; $display("FAIL add_ovf_lit: got %h z%b want 80000000 z0", alu_result, zero);
        end
        do_single(2'b10, 6'h22, 32'd5, 32'd5, "sub_zero");
        n_checks++;
        if (alu_result !== 32'h0 || zero !== 1'b1) begin
            n_errors++; $display("FAIL sub_zero_lit: got %h z%b want 0 z1", alu_result, zero);
        end
        do_single(2'b10, 6'h2a, 32'hFFFF_FFFF, 32'h1, "slt_neg");
        n_checks++;
        if (alu_result !== 32'h1) begin
            n_errors++; $display("FAIL slt_neg_lit: got %h want 1", alu_result);
        end
        do_single(2'b10, 6'h2a, 32'h1, 32'hFFFF_FFFF, "slt_pos");
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            f  = fl[$urandom_range(0, 4)];
            if (i % 8 == 7) f = 6'($urandom_range(0, 15));   // unknown funct codes
            do_single(op, f, XLEN'($urandom), XLEN'($urandom), "rand_single");
        end
        idle_check(1, "single_idle");
    endtask

    task automatic test_branch();
        randomize_ctl();
        aluop = 2'b01; funct = '0; alusrc = 1'b0; m_ctl = 3'b100;
        npcout = 32'h100; s_extendout = 32'hFFFF_FFFC; rdata1 = 32'h55; rdata2 = 32'h55;
        @(negedge clk);
        n_checks++;
        if (EX_MEM_NPC !== 32'hFC || branch !== 1'b1 || zero !== 1'b1 || ex_valid !== 1'b1) begin
            n_errors++; $display("FAIL branch_target: got npc %h br %b z %b v %b want fc 1 1 1",
                                 EX_MEM_NPC, branch, zero, ex_valid);
        end
        else $display("ok branch_target npc=%h", EX_MEM_NPC);
        idle_check(1, "branch_idle");
    endtask

    task automatic test_mul();
        run_mdu(6'h18, 32'h1234_5678, 32'h10, "mul_dir");
        n_checks++;
        if (alu_result !== 32'h2345_6780) begin
            n_errors++; $display("FAIL mul_dir_lit: got %h want 23456780", alu_result);
        end
        run_mdu(6'h18, XLEN'($urandom), XLEN'($urandom), "mul_rand");
        run_mdu(6'h18, XLEN'($urandom), '0, "mul_zero");
        idle_check(2, "mul_idle");
    endtask

    task automatic test_div();
`ifdef EXEC_MDU_DIV_EN
        run_mdu(6'h1a, 32'd100, 32'd7, "divu_dir");
        n_checks++;
        if (alu_result !== 32'd14) begin
            n_errors++; $display("FAIL divu_dir_lit: got %h want e", alu_result);
        end
        run_mdu(6'h1a, 32'd5, 32'd0, "divu_by0");
        n_checks++;
        if (alu_result !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL divu_by0_lit: got %h want ffffffff", alu_result);
        end
        run_mdu(6'h1a, XLEN'($urandom), XLEN'($urandom_range(1, 1000)), "divu_rand");
        run_mdu(6'h1a, XLEN'($urandom_range(0, 50)), XLEN'($urandom), "divu_small");
`else
        do_single(2'b10, 6'h1a, 32'd100, 32'd7, "divu_disabled");
        n_checks++;
        if (alu_result !== 32'h0 || ex_valid !== 1'b1) begin
            n_errors++; $display("FAIL divu_disabled_lit: got %h v%b want 0 v1", alu_result, ex_valid);
        end
`endif
        idle_check(2, "div_idle");
    endtask

    task automatic test_back_to_back();
        logic [5:0] f;
        for (int i = 0; i < 4; i++) begin
            f = (DIV_EN && (i % 2 == 1)) ? 6'h1a : 6'h18;
            run_mdu(f, XLEN'($urandom), XLEN'($urandom_range(0, 300)), "b2b_mdu");
        end
        do_single(2'b00, 6'h00, XLEN'($urandom), XLEN'($urandom), "b2b_after_mdu");
        idle_check(2, "b2b_idle");
    endtask

    task automatic test_flush();
        // Flush in cycle 10 of a mul
        randomize_ctl();
        aluop = 2'b10; funct = 6'h18; rdata1 = XLEN'($urandom); alusrc = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        flush = 1'b1;
        #1;
        n_checks++;
        if (stall_out !== 1'b1) begin
            n_errors++; $display("FAIL flush_busy_stall: got %b want 1", stall_out);
        end
        @(negedge clk);
        n_checks++;
        if (ex_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_busy_valid: got %b want 0", ex_valid);
        end
        in_valid = 1'b0; flush = 1'b0;
        #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_errors++; $display("FAIL flush_busy_idle: got stall %b want 0", stall_out);
        end
        else $display("ok flush_busy");
        do_single(2'b10, 6'h20, XLEN'($urandom), XLEN'($urandom), "add_after_flush");
        idle_check(XLEN + 3, "flush_no_stale");

        // Flush together with an MDU accept: nothing accepted
        randomize_ctl();
        aluop = 2'b10; funct = 6'h18; rdata1 = XLEN'($urandom); flush = 1'b1;
        #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_errors++; $display("FAIL flush_accept_stall: got %b want 0", stall_out);
        end
        else $display("ok flush_accept");
        idle_check(XLEN + 3, "flush_accept_idle");

        // Flush of a valid single-cycle op
        randomize_ctl();
        aluop = 2'b00; rdata1 = XLEN'($urandom); flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ex_valid !== 1'b0 || {branch, memread, memwrite, wb_ctlout} !== 5'b0) begin
            n_errors++; $display("FAIL flush_single: got v%b ctl %b want 0", ex_valid,
                                 {branch, memread, memwrite, wb_ctlout});
        end
        else $display("ok flush_single");

        // Flush in DONE discards the result
        randomize_ctl();
        aluop = 2'b10; funct = 6'h18; rdata1 = XLEN'($urandom); alusrc = 1'b0;
        for (int c = 1; c <= XLEN + 1; c++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ex_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_done: got v%b want 0", ex_valid);
        end
        else $display("ok flush_done");
        idle_check(3, "flush_done_idle");
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_branch();
        test_mul();
        test_div();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_stage_mdu.md
# execute_stage_mdu

Parametrised execute stage with an integrated iterative multiply/divide unit (MDU) and a registered EX/MEM output. It sits between the ID/EX latch and the memory stage. It computes the branch target (NPC + immediate), ALU results and the destination register, then registers them into EX/MEM. It adds what the single-cycle execute stage lacked: configurable datapath width, a valid/stall handshake for multi-cycle operations, and a synchronous flush.

## Interface
Parameters:
- XLEN, 32, datapath width in bits (≥8)
- REGW, 5, register-address width
- CNTW, 6, MDU iteration-counter width; must hold XLEN

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds a valid instruction
- flush  in  1  synchronous squash of EX/MEM and any in-flight MDU op
- wb_ctl / m_ctl  in  2 / 3  control from ID/EX; m_ctl = {branch, memread, memwrite}
- regdst, alusrc  in  1 each  rd select, immediate select
- aluop  in  2  ALU operation class
- npcout, rdata1, rdata2, s_extendout  in  XLEN each
- instrout_2016, instrout_1511  in  REGW each  rt, rd
- funct  in  6  instr[5:0]
- stall_out  out  1  hold IF/ID and ID/EX this cycle
- ex_valid  out  1  EX/MEM contents valid
- wb_ctlout  out  2
- branch, memread, memwrite  out  1 each
- EX_MEM_NPC, alu_result, rdata2out  out  XLEN each
- zero  out  1
- five_bit_muxout  out  REGW  destination register

## Operation
- Operand B = alusrc ? s_extendout : rdata2. Destination = regdst ? rd : rt.
- Branch target = npcout + s_extendout, modulo 2^XLEN, with no shift.
- ALU control: aluop 00 = add; 01 = sub; 11 = add.
- aluop 10 decodes funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1 or 0), 011000 mul, 011010 divu. Any other funct gives result 0.
- add/sub wrap modulo 2^XLEN. zero = (result == 0).
- mul returns the low XLEN bits of the product. Implementation is shift-add, one bit per cycle.
- divu returns the unsigned quotient. Implementation is restoring division, one bit per cycle. Divide by zero returns all-ones.
- MDU FSM has three states: IDLE, BUSY, DONE.
- IDLE → BUSY when in_valid, is an MDU op, and !flush. On entry: operands, control fields and destination are captured; counter cleared.
- BUSY: one iteration per cycle. After XLEN iterations → DONE.
- DONE → IDLE unconditionally. EX/MEM loads the MDU result with the captured control, ex_valid = 1.
- stall_out = (IDLE & in_valid & is MDU op & !flush) | BUSY. It is low in DONE.
- While stall is asserted, EX/MEM loads a bubble: ex_valid = 0 and branch/memread/memwrite/wb_ctlout = 0.
- In DONE, ID/EX still presents the same MDU instruction. It is ignored (not re-accepted), and it advances because stall_out is low.
- Non-MDU valid instruction in IDLE: EX/MEM loads at the next edge, ex_valid = 1.
- in_valid = 0: EX/MEM loads a bubble.
- flush (highest priority): at the edge, EX/MEM loads a bubble and the FSM goes to IDLE. This applies in any state, including DONE, where the result is discarded.

## Timing
- Reset (asynchronous, rst_n low): all EX/MEM outputs 0, ex_valid 0, FSM IDLE, counter 0. stall_out is therefore 0.
- Single-cycle ops: inputs at cycle N appear on the outputs in cycle N+1.
- MDU op presented in cycle 0:
  - stall_out high in cycles 0..XLEN (XLEN+1 cycles).
  - DONE in cycle XLEN+1.
  - Result valid on the outputs in cycle XLEN+2.
  - Bubbles in cycles 1..XLEN+1.
- Back-to-back MDU ops: the second is accepted in the cycle after DONE.
- Flush and accept in the same cycle: flush wins and nothing is accepted.
- Reset deasserted mid-BUSY: restarts from IDLE, and no stale result is emitted.

## Configuration
- EXEC_MDU_DIV_EN defined: divu (funct 011010) goes through the MDU as above.
- Undefined: funct 011010 decodes as unknown, giving a single-cycle result of 0 with no stall. The divider datapath is removed; mul is unaffected.

## Test plan
- Reset mid-mul: rst_n low in BUSY, then released with in_valid=0 → all outputs 0, ex_valid 0, stall_out 0.
- Single-cycle ops, XLEN=32: add 0x7FFFFFFF+1 → alu_result 0x80000000, zero 0. sub 5−5 → 0, zero 1. slt −1<1 → 1. Each appears one cycle after input.
- Branch target: npcout 0x100, s_extendout 0xFFFFFFFC, branch=1 → EX_MEM_NPC 0xFC, branch 1.
- mul 0x12345678 × 0x10 → alu_result 0x23456780 at cycle 34. stall_out high in cycles 0–32 and bubbles in cycles 1–33.
- divu (EXEC_MDU_DIV_EN): 100/7 → 14; 5/0 → 0xFFFFFFFF. Without the macro: funct 011010 → 0 next cycle, no stall.
- flush in cycle 10 of a mul → next-cycle ex_valid 0 and FSM IDLE. A subsequent add completes normally one cycle later.
